// File: rtl/dualshock_scheduler.sv
// Frame sequencer for a shared DualShock SPI byte engine: per-pad config frames, then periodic polls.
// Optional motor support is enabled by defining RUMBLE_EN (adds the 4D map frame and poll motor bytes).
module dualshock_scheduler #(
  parameter int FREQ    = 50_000_000,
  parameter int POLL_HZ = 60,
  parameter int GAP_CYC = 2000
) (
  input  logic        clk,
  input  logic        I_RST,
  output logic        O_XFER_REQ,
  output logic [7:0]  O_XFER_DAT,
  input  logic        I_XFER_ACK,
  input  logic [7:0]  I_XFER_RXD,
  output logic [1:0]  O_SEL,
  output logic [15:0] O_BTNS0,
  output logic [15:0] O_BTNS1,
  output logic [31:0] O_STICKS0,
  output logic [31:0] O_STICKS1,
  output logic [1:0]  O_VALID,
  input  logic [1:0]  I_RUMBLE_S,
  input  logic [15:0] I_RUMBLE_L,
  output logic [2:0]  dbg_state
);
  localparam int PERIOD = FREQ / POLL_HZ;
  localparam int TW = $clog2(PERIOD + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_REQ, S_WAIT, S_END} state_t;
  typedef enum logic [2:0] {F_ENTER, F_ANALOG, F_MAP, F_EXIT, F_POLL} frame_t;

  state_t        state_q, state_d;
  frame_t        kind;
  logic          pad, pending, aborted;
  logic [3:0]    idx, len;
  logic [7:0]    rx_q;
  logic [47:0]   rbuf;
  logic [TW-1:0] tick_cnt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    init_done;
  logic          tick, start, nib_ok, bad_byte, last;
  logic [7:0]    cmd, rb3, rb4;
  logic [15:0]   btns_new;
  logic [31:0]   sticks_new;

`ifdef RUMBLE_EN
  logic [1:0]  rum_s;
  logic [15:0] rum_l;

  // Motor demands are sampled once per tick so command bytes never change under a pending request.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      rum_s <= '0;
      rum_l <= '0;
    end else if (start) begin
      rum_s <= I_RUMBLE_S;
      rum_l <= I_RUMBLE_L;
    end
  end

  assign rb3 = rum_s[pad] ? 8'hFF : 8'h00;
  assign rb4 = pad ? rum_l[15:8] : rum_l[7:0];
`else
  logic unused_rumble;
  assign unused_rumble = &{1'b0, I_RUMBLE_S, I_RUMBLE_L};
  assign rb3 = 8'h00;
  assign rb4 = 8'h00;
`endif

  assign tick     = (tick_cnt == TW'(PERIOD - 1));
  assign start    = (state_q == S_IDLE) && (tick || pending);
  assign nib_ok   = (rx_q[3:0] == 4'd1) || (rx_q[3:0] == 4'd3);
  assign bad_byte = ((idx == 4'd1) && ((rx_q == 8'hFF) || (kind == F_POLL && !nib_ok))) ||
                    ((idx == 4'd2) && (rx_q != 8'h5A));
  assign last     = (idx == len - 4'd1);
  assign dbg_state = state_q;

  // Received bytes 3.. are shifted in from the top, so a 5-byte frame leaves its buttons in [47:32].
  assign btns_new   = (len == 4'd5) ? rbuf[47:32] : rbuf[15:0];
  assign sticks_new = (len == 4'd5) ? 32'h80808080 : rbuf[47:16];

  always_comb begin
    cmd = 8'h00;
    case (idx)
      4'd0: cmd = 8'h01;
      4'd1: begin
        case (kind)
          F_ENTER, F_EXIT: cmd = 8'h43;
          F_ANALOG:        cmd = 8'h44;
          F_MAP:           cmd = 8'h4D;
          default:         cmd = 8'h42;
        endcase
      end
      4'd3: begin
        if (kind == F_ENTER || kind == F_ANALOG) cmd = 8'h01;
        else if (kind == F_POLL)                 cmd = rb3;
      end
      4'd4: begin
        case (kind)
          F_ANALOG: cmd = 8'h03;
          F_MAP:    cmd = 8'h01;
          F_EXIT:   cmd = 8'h5A;
          F_POLL:   cmd = rb4;
          default:  cmd = 8'h00;
        endcase
      end
      4'd5, 4'd6, 4'd7, 4'd8: begin
        if (kind == F_MAP)       cmd = 8'hFF;
        else if (kind == F_EXIT) cmd = 8'h5A;
      end
      default: cmd = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Handshake: REQ/DAT are held from S_REQ entry until ACK; S_WAIT guarantees one idle cycle.
  always_comb begin
    state_d    = state_q;
    O_XFER_REQ = 1'b0;
    O_XFER_DAT = 8'h00;
    O_SEL      = 2'b11;
    case (state_q)
      S_IDLE: if (start) state_d = S_GAP;
      S_GAP:  if (gap_cnt == GW'(GAP_CYC - 1)) state_d = S_REQ;
      S_REQ: begin
        O_XFER_REQ = 1'b1;
        O_XFER_DAT = cmd;
        O_SEL[pad] = 1'b0;
        if (I_XFER_ACK) state_d = S_WAIT;
      end
      S_WAIT: begin
        O_SEL[pad] = 1'b0;
        state_d = (bad_byte || last) ? S_END : S_REQ;
      end
      S_END:   state_d = ((!aborted && kind != F_POLL) || !pad) ? S_GAP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      tick_cnt  <= '0;
      gap_cnt   <= '0;
      pending   <= 1'b0;
      pad       <= 1'b0;
      kind      <= F_ENTER;
      idx       <= '0;
      len       <= 4'd9;
      rx_q      <= '0;
      rbuf      <= '0;
      aborted   <= 1'b0;
      init_done <= 2'b00;
      O_BTNS0   <= 16'hFFFF;
      O_BTNS1   <= 16'hFFFF;
      O_STICKS0 <= 32'h80808080;
      O_STICKS1 <= 32'h80808080;
      O_VALID   <= 2'b00;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (state_q == S_IDLE) pending <= 1'b0;
      else if (tick)         pending <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pad     <= 1'b0;
            kind    <= init_done[0] ? F_POLL : F_ENTER;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          idx     <= '0;
          len     <= (kind == F_ENTER) ? 4'd5 : 4'd9;
          aborted <= 1'b0;
        end
        S_REQ: if (I_XFER_ACK) rx_q <= I_XFER_RXD;
        S_WAIT: begin
          if (idx >= 4'd3) rbuf <= {rx_q, rbuf[47:8]};
          if (idx == 4'd1 && kind == F_POLL) len <= 4'd3 + {rx_q[2:0], 1'b0};
          if (bad_byte)   aborted <= 1'b1;
          else if (!last) idx <= idx + 4'd1;
        end
        S_END: begin
          gap_cnt <= '0;
          if (aborted) begin
            O_VALID[pad]   <= 1'b0;
            init_done[pad] <= 1'b0;
          end else begin
            case (kind)
              F_ENTER: kind <= F_ANALOG;
`ifdef RUMBLE_EN
              F_ANALOG: kind <= F_MAP;
`else
              F_ANALOG: kind <= F_EXIT;
`endif
              F_MAP: kind <= F_EXIT;
              F_EXIT: begin
                init_done[pad] <= 1'b1;
                kind           <= F_POLL;
              end
              default: begin
                O_VALID[pad] <= 1'b1;
                if (!pad) begin
                  O_BTNS0   <= btns_new;
                  O_STICKS0 <= sticks_new;
                end else begin
                  O_BTNS1   <= btns_new;
                  O_STICKS1 <= sticks_new;
                end
              end
            endcase
          end
          // Pad0's sequence for this tick is over; hand over to pad1.
          if (aborted || kind == F_POLL) begin
            pad  <= 1'b1;
            kind <= init_done[1] ? F_POLL : F_ENTER;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
